sram_1r1w_param: RTL and testbench

Parametrised single-clock 1R1W SRAM behavioural model. It is the successor to the fixed 512x128 dual-clock macro model. Adds configurable width, depth and mask granularity, a selectable read pipeline depth, read-valid signalling, and a post-reset clear sequencer. Used in the testbench/VLSI flow wherever generated RAMs are instantiated behind a common clock.

---
 rtl/sram_pkg.sv | 40 ++++
 rtl/sram_byte_merge.sv | 42 ++++
 rtl/sram_1r1w_param.sv | 194 +++++++++++++++++++
 tb/tb_sram_1r1w_param.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the parametrised 1R1W SRAM model.
//   sram_state_e : array sequencer state (clearing after reset / serving traffic)
//   RD_LAT_MIN/MAX : the two supported read latencies
//   expand_mask  : turns a per-lane write mask into a per-bit enable
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest word the mask helper can expand; callers slice the low WIDTH bits.
  localparam int MAX_WIDTH = 1024;

  // Lane k of the mask enables bits [k*gran +: gran]. Built with shifts so the
  // lane size can be a runtime argument while staying constant at each call.
  function automatic logic [MAX_WIDTH-1:0] expand_mask(
    input logic [MAX_WIDTH-1:0] mask,
    input int                   gran
  );
    logic [MAX_WIDTH-1:0] bits;
    logic [MAX_WIDTH-1:0] lane_ones;
    logic [MAX_WIDTH-1:0] m;
    bits      = '0;
    m         = mask;
    lane_ones = ~({MAX_WIDTH{1'b1}} << gran);
    for (int l = 0; l < MAX_WIDTH / gran; l++) begin
      if (m[0]) bits = bits | (lane_ones << (l * gran));
      m = m >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// -----------------------------------------------------------------------------
// sram_byte_merge
// Combinational lane merge: enabled lanes take new_word, the rest keep
// old_word. Feeds both the array write data and the same-address read bypass.
//   old_word    in  WIDTH  current array contents
//   new_word    in  WIDTH  incoming write data
//   lane_mask   in  LANES  1 = take the lane from new_word
//   merged_word out WIDTH  merged result
// -----------------------------------------------------------------------------
module sram_byte_merge
  import sram_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int MASK_GRAN = 8,
  parameter int LANES     = WIDTH / MASK_GRAN
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  input  logic [LANES-1:0] lane_mask,
  output logic [WIDTH-1:0] merged_word
);

  logic [MAX_WIDTH-1:0] bit_en_full;
  logic [WIDTH-1:0]     bit_en;

  always_comb begin
    bit_en_full = expand_mask(MAX_WIDTH'(lane_mask), MASK_GRAN);
    bit_en      = bit_en_full[WIDTH-1:0];
    merged_word = (new_word & bit_en) | (old_word & ~bit_en);
  end

  generate
    if (WIDTH > MAX_WIDTH) begin : g_too_wide
      $error("sram_byte_merge: WIDTH exceeds sram_pkg::MAX_WIDTH");
    end else if (WIDTH < MAX_WIDTH) begin : g_hi_bits
      // Bits above WIDTH are always zero for a WIDTH-sized mask.
      logic unused_hi;
      assign unused_hi = |bit_en_full[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/sram_1r1w_param.sv
// -----------------------------------------------------------------------------
// sram_1r1w_param
// Single-clock 1R1W SRAM behavioural model with lane write mask, 1- or
// 2-cycle read pipeline, read-valid pulse and an optional post-reset clear.
//
// Ports
//   CE        in  1         clock, rising edge
//   RSTB      in  1         asynchronous active-low reset (array not reset)
//   CSB1      in  1         read select, active-low
//   A1        in  ADDR_W    read address
//   O1        out WIDTH     read data, holds between reads
//   O1_VALID  out 1         pulse: O1 updated this cycle
//   CSB2      in  1         write select, active-low
//   WEB2      in  1         write enable, active-low
//   A2        in  ADDR_W    write address
//   I2        in  WIDTH     write data
//   WBM2      in  LANES     lane mask, 1 = write lane
//   INIT_DONE out 1         array ready for traffic
//   DROP      out 1         pulse: a request arrived while clearing
//
// Build option
//   SRAM_WR_BYPASS_EN : when defined, a read and write to the same in-range
//   address on one edge returns the merged (new) data; otherwise the read
//   returns the pre-write contents.
// -----------------------------------------------------------------------------
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int MASK_GRAN  = 8,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                       CE,
  input  logic                       RSTB,
  input  logic                       CSB1,
  input  logic [ADDR_W-1:0]          A1,
  output logic [WIDTH-1:0]           O1,
  output logic                       O1_VALID,
  input  logic                       CSB2,
  input  logic                       WEB2,
  input  logic [ADDR_W-1:0]          A2,
  input  logic [WIDTH-1:0]           I2,
  input  logic [WIDTH/MASK_GRAN-1:0] WBM2,
  output logic                       INIT_DONE,
  output logic                       DROP
);

  localparam int LANES = WIDTH / MASK_GRAN;

`ifdef SRAM_WR_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
      $error("sram_1r1w_param: WIDTH must be a multiple of MASK_GRAN");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("sram_1r1w_param: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];

  sram_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] o1_p2_q, o1_p2_d;
  logic             vld_p2_q, vld_p2_d;

  logic             rd_req, wr_req, rd_fire;
  logic             rd_in_range, wr_in_range;
  logic [WIDTH-1:0] old_wr_word, merged_word, rd_word;
  logic             mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign rd_req      = ~CSB1;
  assign wr_req      = ~CSB2 & ~WEB2;
  assign rd_in_range = {1'b0, A1} < DEPTH_X;
  assign wr_in_range = {1'b0, A2} < DEPTH_X;
  assign rd_fire     = (state_q == ST_READY) & rd_req;

  // ---- stage p0: array access, lane merge, same-address bypass ----
  assign old_wr_word = wr_in_range ? mem[A2] : '0;

  sram_byte_merge #(
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .LANES     (LANES)
  ) u_merge (
    .old_word    (old_wr_word),
    .new_word    (I2),
    .lane_mask   (WBM2),
    .merged_word (merged_word)
  );

  // When A1 == A2 the merge output is exactly "old mem[A1] with enabled lanes
  // replaced", so the write-path merge doubles as the bypass word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[A1];
    if (BYPASS_EN && wr_req && wr_in_range && rd_in_range && (A1 == A2))
      rd_word = merged_word;
  end

  // Clear sequencer owns the write port while in INIT.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = A2;
    mem_wdata = merged_word;
    if (state_q == ST_INIT) begin
      mem_we    = RSTB;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_req && wr_in_range) begin
      mem_we    = RSTB;
    end
  end

  always_ff @(posedge CE) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Sequencer: INIT walks every address once, then hands over to traffic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    if (state_q == ST_INIT) begin
      drop_d = rd_req | wr_req;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---- stage p1 (RD_LAT=2 only) / stage p2: output register ----
  always_comb begin
    rd_data_p1_d = rd_data_p1_q;
    vld_p1_d     = 1'b0;
    o1_p2_d      = o1_p2_q;
    vld_p2_d     = 1'b0;
    if (RD_LAT == RD_LAT_MAX) begin
      vld_p1_d = rd_fire;
      if (rd_fire) rd_data_p1_d = rd_word;
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) o1_p2_d = rd_data_p1_q;
    end else begin
      vld_p2_d = rd_fire;
      if (rd_fire) o1_p2_d = rd_word;
    end
  end

  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q      <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      rd_data_p1_q <= '0;
      vld_p1_q     <= 1'b0;
      o1_p2_q      <= '0;
      vld_p2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      rd_data_p1_q <= rd_data_p1_d;
      vld_p1_q     <= vld_p1_d;
      o1_p2_q      <= o1_p2_d;
      vld_p2_q     <= vld_p2_d;
    end
  end

  assign O1        = o1_p2_q;
  assign O1_VALID  = vld_p2_q;
  assign DROP      = drop_q;
  assign INIT_DONE = (state_q == ST_READY);

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Two instances share clock and reset: u_a is the default 512x128, RD_LAT=1
// build; u_b is a 40-word, RD_LAT=2 build (non power-of-two depth, so
// addresses 40..63 are out of range). A behavioural model holds the array
// contents and a queue of pending read results keyed by the edge they are due.
module tb_sram_1r1w_param;

  localparam int W = 128;
  localparam int G = 8;
  localparam int L = W / G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstb = 1'b0;
  logic         rd_req [2];
  logic         wr_req [2];
  logic [8:0]   ra [2];
  logic [8:0]   wa [2];
  logic [W-1:0] wd [2];
  logic [L-1:0] wm [2];

  logic [W-1:0] o1_a, o1_b;
  logic         v_a, v_b, dn_a, dn_b, dr_a, dr_b;

  sram_1r1w_param u_a (
    .CE(clk), .RSTB(rstb),
    .CSB1(~rd_req[0]), .A1(ra[0]), .O1(o1_a), .O1_VALID(v_a),
    .CSB2(~wr_req[0]), .WEB2(~wr_req[0]), .A2(wa[0]), .I2(wd[0]), .WBM2(wm[0]),
    .INIT_DONE(dn_a), .DROP(dr_a)
  );

  sram_1r1w_param #(.WIDTH(128), .DEPTH(40), .MASK_GRAN(8), .RD_LAT(2), .INIT_CLEAR(1)) u_b (
    .CE(clk), .RSTB(rstb),
    .CSB1(~rd_req[1]), .A1(ra[1][5:0]), .O1(o1_b), .O1_VALID(v_b),
    .CSB2(~wr_req[1]), .WEB2(~wr_req[1]), .A2(wa[1][5:0]), .I2(wd[1]), .WBM2(wm[1]),
    .INIT_DONE(dn_b), .DROP(dr_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    logic [W-1:0] val;
  } rd_t;

  int           dep [2] = '{512, 40};
  int           lat [2] = '{1, 2};
  logic [W-1:0] mm [2][512];
  int           init_cnt [2];
  logic [W-1:0] last [2];
  logic         exp_drop [2];
  rd_t          q_a [$];
  rd_t          q_b [$];
  int           edge_n = 0;
  int           since_rel = 0;
  int           rise_cyc = -1;

  int checks = 0;
  int errors = 0;

`ifdef SRAM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                              input logic [L-1:0] mask);
    logic [W-1:0] r;
    r = old_w;
    for (int k = 0; k < L; k++)
      if (mask[k]) r[k*G +: G] = new_w[k*G +: G];
    return r;
  endfunction

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      init_cnt[d] = 0;
      last[d]     = '0;
      exp_drop[d] = 1'b0;
      // The clear sequence zeroes everything before any read is served.
      for (int i = 0; i < 512; i++) mm[d][i] = '0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_edge;
    rd_t          e;
    logic [W-1:0] val;
    for (int d = 0; d < 2; d++) begin
      if (init_cnt[d] < dep[d]) begin
        exp_drop[d] = rd_req[d] | wr_req[d];
        init_cnt[d]++;
      end else begin
        exp_drop[d] = 1'b0;
        if (rd_req[d]) begin
          val = (int'(ra[d]) < dep[d]) ? mm[d][ra[d]] : '0;
          if (BYP && wr_req[d] && wa[d] == ra[d] && int'(ra[d]) < dep[d])
            val = lane_merge(mm[d][ra[d]], wd[d], wm[d]);
          e.due = edge_n + lat[d] - 1;
          e.val = val;
          if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        if (wr_req[d] && int'(wa[d]) < dep[d])
          mm[d][wa[d]] = lane_merge(mm[d][wa[d]], wd[d], wm[d]);
      end
    end
  endtask

  task automatic check_outputs;
    logic exp_v;
    rd_t  e;
    for (int d = 0; d < 2; d++) begin
      exp_v = 1'b0;
      if (d == 0 && q_a.size() > 0 && q_a[0].due == edge_n) begin
        e = q_a.pop_front(); exp_v = 1'b1; last[0] = e.val;
      end
      if (d == 1 && q_b.size() > 0 && q_b[0].due == edge_n) begin
        e = q_b.pop_front(); exp_v = 1'b1; last[1] = e.val;
      end
      chk($sformatf("o1_valid[%0d]@%0d", d, edge_n), W'(d == 0 ? v_a : v_b), W'(exp_v));
      chk($sformatf("o1[%0d]@%0d", d, edge_n), d == 0 ? o1_a : o1_b, last[d]);
      chk($sformatf("drop[%0d]@%0d", d, edge_n), W'(d == 0 ? dr_a : dr_b), W'(exp_drop[d]));
      chk($sformatf("init_done[%0d]@%0d", d, edge_n), W'(d == 0 ? dn_a : dn_b),
          W'(init_cnt[d] >= dep[d]));
    end
  endtask

  task automatic step;
    edge_n++;
    since_rel++;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    if (rise_cyc < 0 && dn_a) rise_cyc = since_rel;
  endtask

  task automatic idle;
    for (int d = 0; d < 2; d++) begin
      rd_req[d] = 1'b0; wr_req[d] = 1'b0;
      ra[d] = '0; wa[d] = '0; wd[d] = '0; wm[d] = '0;
    end
  endtask

  task automatic rand_traffic;
    for (int d = 0; d < 2; d++) begin
      rd_req[d] = ($urandom_range(0, 99) < 50);
      wr_req[d] = ($urandom_range(0, 99) < 50);
      if (d == 0) begin
        ra[d] = 9'($urandom_range(0, 15));
        wa[d] = 9'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) ra[d] = 9'd511;
        if ($urandom_range(0, 9) == 0) wa[d] = 9'd511;
      end else begin
        ra[d] = 9'($urandom_range(0, 63));
        wa[d] = 9'($urandom_range(0, 63));
      end
      wd[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
      wm[d] = ($urandom_range(0, 3) == 0) ? '1 : L'($urandom());
    end
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic do_reset;
    @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("rst_o1_a", o1_a, '0);
    chk("rst_o1_b", o1_b, '0);
    chk("rst_vld_a", W'(v_a), '0);
    chk("rst_vld_b", W'(v_b), '0);
    chk("rst_done_a", W'(dn_a), '0);
    chk("rst_done_b", W'(dn_b), '0);
    chk("rst_drop_a", W'(dr_a), '0);
    chk("rst_drop_b", W'(dr_b), '0);
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    since_rel = 0;
    rise_cyc  = -1;
  endtask

  initial begin
    logic [W-1:0] exp_same;
    idle();
    model_reset();
    do_reset();

    // Read request during the clear, on the 10th edge after release.
    repeat (9) step();
    rd_req[0] = 1'b1; ra[0] = 9'd5;
    step();
    chk("init_rd_drop", W'(dr_a), W'(1'b1));
    chk("init_rd_vld", W'(v_a), '0);
    chk("init_rd_o1", o1_a, '0);
    idle();
    step();
    chk("init_drop_clear", W'(dr_a), '0);

    // Random traffic through u_a's clear; u_b is live after 40 edges.
    while (since_rel < 520) begin
      rand_traffic();
      step();
    end
    chk("init_done_rise_cycle", W'(rise_cyc), W'(512));

    // u_a: cleared array reads zero.
    idle();
    rd_req[0] = 1'b1; ra[0] = 9'd100;
    step();
    chk("clear_rd_vld", W'(v_a), W'(1'b1));
    chk("clear_rd_o1", o1_a, '0);

    // u_a: two masked writes to address 3 then read back.
    idle();
    wr_req[0] = 1'b1; wa[0] = 9'd3; wd[0] = {16{8'hAA}}; wm[0] = 16'h00FF;
    step();
    wd[0] = {16{8'h55}}; wm[0] = 16'hFF00;
    step();
    idle();
    rd_req[0] = 1'b1; ra[0] = 9'd3;
    step();
    chk("mask_merge", o1_a, {{8{8'h55}}, {8{8'hAA}}});
    idle();
    step();
    chk("o1_hold", o1_a, {{8{8'h55}}, {8{8'hAA}}});
    chk("o1_vld_pulse", W'(v_a), '0);

    // u_b: RD_LAT=2 back-to-back reads.
    for (int i = 1; i <= 3; i++) begin
      idle();
      wr_req[1] = 1'b1; wa[1] = 9'(i); wd[1] = W'(i * 8'h11); wm[1] = '1;
      step();
    end
    idle();
    rd_req[1] = 1'b1; ra[1] = 9'd1;
    step();
    chk("lat2_first_edge_vld", W'(v_b), '0);
    ra[1] = 9'd2;
    step();
    chk("lat2_o1_11", o1_b, W'(8'h11));
    chk("lat2_vld_1", W'(v_b), W'(1'b1));
    ra[1] = 9'd3;
    step();
    chk("lat2_o1_22", o1_b, W'(8'h22));
    idle();
    step();
    chk("lat2_o1_33", o1_b, W'(8'h33));
    chk("lat2_vld_3", W'(v_b), W'(1'b1));
    step();
    chk("lat2_vld_end", W'(v_b), '0);

    // Same-edge read/write to address 7 on both instances.
    idle();
    for (int d = 0; d < 2; d++) begin
      wr_req[d] = 1'b1; wa[d] = 9'd7; wd[d] = '0; wm[d] = '1;
    end
    step();
    for (int d = 0; d < 2; d++) begin
      wd[d] = '1; rd_req[d] = 1'b1; ra[d] = 9'd7;
    end
    exp_same = BYP ? '1 : '0;
    step();
    chk("same_addr_a", o1_a, exp_same);
    idle();
    step();
    chk("same_addr_b", o1_b, exp_same);
    rd_req[0] = 1'b1; ra[0] = 9'd7;
    step();
    chk("same_addr_after", o1_a, '1);

    // u_b out-of-range read returns zero with valid.
    idle();
    rd_req[1] = 1'b1; ra[1] = 9'd45;
    wr_req[1] = 1'b1; wa[1] = 9'd50; wd[1] = '1; wm[1] = '1;
    step();
    idle();
    step();
    chk("oor_vld", W'(v_b), W'(1'b1));
    chk("oor_o1", o1_b, '0);

    repeat (400) begin
      rand_traffic();
      step();
    end

    // Reset with a read held in u_b's p1 stage.
    idle();
    rd_req[1] = 1'b1; ra[1] = 9'd7;
    step();
    idle();
    do_reset();
    repeat (60) begin
      rand_traffic();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
